// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and data requesters; data first, strict alternation when both wait.
// Latency >= 2 cycles (grant cycle then ram_ready); requesters stall on iwait/dwait until served or timed out.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_WAIT = 15,
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hBAD1BAD1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              bus_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] INSTR = 2'd2;

  logic [1:0]    state;
  logic [1:0]    nextState;
  logic [CW-1:0] cnt;
  logic          dReq;
  logic          inData;
  logic          inInstr;
  logic          active;
  logic          timeout;
  logic          done;

  assign dReq = dREN | dWEN;

  // Reset gates the service view so an access aborted by RST never reports completion.
  assign inData  = (state == DATA)  & ~RST;
  assign inInstr = (state == INSTR) & ~RST;

  // A withdrawn request (flush) is no longer active, so a late ram_ready is ignored.
  assign active  = inData ? dReq : (inInstr ? iREN : 1'b0);
  assign timeout = active & ~ram_ready & (cnt == CNT_LAST);
  assign done    = active & (ram_ready | timeout);

  always_comb begin
    ram_REN   = 1'b0;
    ram_WEN   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    iload     = '0;
    dload     = '0;
    iwait     = iREN;
    dwait     = dReq;
    if (inData) begin
      ram_addr  = daddr;
      ram_store = dstore;
      ram_WEN   = dWEN;
      ram_REN   = dREN & ~dWEN;
      if (done) begin
        dwait = 1'b0;
        dload = timeout ? ERR_WORD : ram_load;
      end
    end else if (inInstr) begin
      ram_addr = iaddr;
      ram_REN  = 1'b1;
      if (done) begin
        iwait = 1'b0;
        iload = timeout ? ERR_WORD : ram_load;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (dReq)      nextState = DATA;
        else if (iREN) nextState = INSTR;
      end
      DATA: begin
        if (!dReq || timeout) nextState = IDLE;
        else if (ram_ready)   nextState = iREN ? INSTR : IDLE;
      end
      INSTR: begin
        if (!iREN || timeout) nextState = IDLE;
        else if (ram_ready)   nextState = dReq ? DATA : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState != state)
        cnt <= '0;
      else if (active && !ram_ready && cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      if (timeout)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle checked against a transaction-level owner/age model.
module tb_mem_arbiter;
  localparam int MW = 4;
  localparam logic [31:0] ERR = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ram_ready, iwait, dwait, ram_REN, ram_WEN, bus_err;
  logic [31:0] iaddr, daddr, dstore, iload, dload, ram_addr, ram_store, ram_load;

  int checks = 0;
  int passes = 0;

  // Model: who owns the RAM (0 none, 1 data, 2 fetch) and how many unready service cycles elapsed.
  int owner = 0;
  int age = 0;
  bit errM = 0;
  bit iDone = 0;
  bit dDone = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW), .ERR_WORD(ERR)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Called just after a falling edge with inputs settled; checks, then advances one clock.
  task automatic cycle();
    int own, nOwn, nAge;
    bit dq, act, to, ok, nErr;
    #1;
    own = RST ? 0 : owner;
    dq  = dREN | dWEN;
    act = (own == 1) ? dq : ((own == 2) ? iREN : 1'b0);
    to  = act && !ram_ready && (age == MW - 1);
    ok  = act && ram_ready;
    chk("iwait", iwait, iREN && !(own == 2 && (ok || to)));
    chk("dwait", dwait, dq && !(own == 1 && (ok || to)));
    chk("iload", iload, (own == 2 && ok) ? ram_load : ((own == 2 && to) ? ERR : 32'h0));
    chk("dload", dload, (own == 1 && ok) ? ram_load : ((own == 1 && to) ? ERR : 32'h0));
    chk("ram_REN", ram_REN, own == 2 || (own == 1 && dREN && !dWEN));
    chk("ram_WEN", ram_WEN, own == 1 && dWEN);
    chk("ram_addr", ram_addr, (own == 2) ? iaddr : ((own == 1) ? daddr : 32'h0));
    chk("ram_store", ram_store, (own == 1) ? dstore : 32'h0);
    chk("bus_err", bus_err, errM);
    nOwn = own; nAge = age + 1; nErr = errM;
    if (RST) begin
      nOwn = 0; nAge = 0; nErr = 0;
    end else if (own == 0) begin
      nOwn = dq ? 1 : (iREN ? 2 : 0); nAge = 0;
    end else if (!act || to) begin
      nOwn = 0; nAge = 0; nErr = errM | to;
    end else if (ok) begin
      nOwn = (own == 1) ? (iREN ? 2 : 0) : (dq ? 1 : 0); nAge = 0;
    end
    iDone = (own == 2) && (ok || to);
    dDone = (own == 1) && (ok || to);
    @(posedge CLK);
    owner = nOwn; age = nAge; errM = nErr;
    @(negedge CLK);
  endtask

  initial begin
    int dServ;
    RST = 1; iREN = 1; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ram_load = 32'h1234_5678;
    @(negedge CLK);
    cycle(); cycle();
    RST = 0; iREN = 0;
    cycle();

    // Single fetch
    iREN = 1; iaddr = 32'h100;
    chk("fetch idle ram_REN", ram_REN, 1'b0);
    cycle();
    ram_ready = 1; ram_load = 32'h2402000A;
    #1 chk("fetch ram_addr", ram_addr, 32'h100);
    chk("fetch iwait", iwait, 1'b0);
    chk("fetch iload", iload, 32'h2402000A);
    cycle();
    iREN = 0; ram_ready = 0;
    cycle();

    // Simultaneous fetch and store: data first, fetch immediately after
    iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    cycle();
    #1 chk("both WEN", ram_WEN, 1'b1);
    chk("both store", ram_store, 32'hDEADBEEF);
    cycle();
    ram_ready = 1;
    #1 chk("both dwait", dwait, 1'b0);
    chk("both iwait held", iwait, 1'b1);
    cycle();
    dWEN = 0; ram_ready = 0;
    #1 chk("both instr REN", ram_REN, 1'b1);
    chk("both instr addr", ram_addr, 32'h200);
    cycle();
    ram_ready = 1;
    #1 chk("both iwait", iwait, 1'b0);
    cycle();
    iREN = 0; ram_ready = 0;
    cycle();

    // Starvation: both held, RAM always ready -> grants alternate D,I,D,I
    dREN = 1; daddr = 32'h40; iREN = 1; iaddr = 32'h300; ram_ready = 1;
    cycle();
    for (int k = 1; k <= 6; k++) begin
      #1 chk("alt grant", ram_addr, (k % 2 == 1) ? 32'h40 : 32'h300);
      cycle();
    end
    dREN = 0; iREN = 0; ram_ready = 0;
    cycle(); cycle();

    // Flush: iREN dropped in INSTR with ram_ready the same cycle
    iREN = 1; iaddr = 32'h400;
    cycle(); cycle();
    iREN = 0; ram_ready = 1; ram_load = 32'hFFFF0000;
    #1 chk("flush iwait", iwait, 1'b0);
    chk("flush iload", iload, 32'h0);
    cycle();
    ram_ready = 0;
    #1 chk("flush idle", ram_REN, 1'b0);
    cycle();

    // Timeout: 4th unready service cycle returns the error word
    dREN = 1; daddr = 32'h500;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      #1 chk("to dwait held", dwait, 1'b1);
      cycle();
    end
    #1 chk("to dwait", dwait, 1'b0);
    chk("to dload", dload, ERR);
    cycle();
    dREN = 0;
    #1 chk("to bus_err", bus_err, 1'b1);
    cycle();

    // Randomized traffic with protocol-following requesters
    dServ = 0;
    for (int n = 0; n < 3000; n++) begin
      if (iDone) iREN = 0;
      else if (!iREN && $urandom_range(0, 2) == 0) begin iREN = 1; iaddr = $urandom; end
      else if (iREN && $urandom_range(0, 19) == 0) iREN = 0;
      if (dDone) begin dREN = 0; dWEN = 0; end
      else if (!(dREN | dWEN) && $urandom_range(0, 2) == 0) begin
        dWEN = $urandom_range(0, 1) == 1; dREN = !dWEN || $urandom_range(0, 3) == 0;
        daddr = $urandom; dstore = $urandom;
      end else if (dREN && !dWEN && $urandom_range(0, 19) == 0) dREN = 0;
      ram_ready = $urandom_range(0, 9) < 4;
      ram_load = $urandom;
      #1;
      if ((dREN | dWEN) && !dwait && ram_ready && iREN) dServ++;
      if (iREN && !iwait) chk("starve bound", dServ <= 2, 1'b1);
      if (!iREN || !iwait) dServ = 0;
      cycle();
    end
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    cycle(); cycle();

    // Reset mid-service aborts the access; request is re-granted afterwards
    dREN = 1; daddr = 32'h600;
    cycle(); cycle();
    RST = 1; ram_ready = 1;
    #1 chk("rst no completion", dwait, 1'b1);
    cycle();
    RST = 0; ram_ready = 0;
    #1 chk("rst idle REN", ram_REN, 1'b0);
    chk("rst bus_err", bus_err, 1'b0);
    cycle();
    #1 chk("rst regrant", ram_addr, 32'h600);
    cycle();
    ram_ready = 1;
    cycle();
    dREN = 0; ram_ready = 0;
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
